// File: rtl/preamble_burst_capture_pkg.sv
// Shared definitions for the preamble burst capture block: capture FSM
// encoding, default widths, and the header-word flag that is set when
// PREAMBLE_CAPTURE_TS_EN is defined.
package preamble_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } cap_state_t;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int MAX_LEN_DEF     = 4095;
    localparam int FIFO_AWIDTH_DEF = 12;
    localparam int CFG_WIDTH       = 16;
    localparam int MISS_WIDTH      = 8;

    // When set, every packet starts with a timestamp header word.
`ifdef PREAMBLE_CAPTURE_TS_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

endpackage

// File: rtl/preamble_burst_capture_if.sv
// AXI-Stream style output bus of the burst capture block ({I,Q} words + tlast).
// master: drives tdata/tvalid/tlast, samples tready. slave: the reverse.
// Transfer happens on any cycle where tvalid & tready are both high.
interface preamble_burst_capture_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [2*DATA_WIDTH-1:0] tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pbc_fifo.sv
// Synchronous first-word-fall-through FIFO (data word with tlast packed in bit 0).
// Latency: a word pushed at edge k appears on out_dat/out_vld after edge k+1.
// Backpressure: out_dat is held while out_vld & !out_rdy; push is never refused,
// the writer must keep push count within 'free' (occupancy includes the output register).
// Ports: clk, reset (sync, active-high flush), push/push_dat, out_dat/out_vld/out_rdy, free.
module pbc_fifo #(
    parameter int WIDTH  = 33,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_dat,
    output logic [WIDTH-1:0]  out_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [AWIDTH:0]   free
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam int CW    = AWIDTH + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   mem_cnt;   // words in the array, excluding the output register
    logic              pop;
    logic              load;

    assign pop  = out_vld & out_rdy;
    // Refill the output register whenever it is empty or being consumed.
    assign load = (mem_cnt != '0) && (!out_vld || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            if (load) begin
                rd_ptr  <= rd_ptr + AWIDTH'(1);
                out_dat <= mem[rd_ptr];
                out_vld <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
            mem_cnt <= mem_cnt + CW'(push) - CW'(load);
        end
    end

    // Total occupancy counts the word parked in the output register too.
    assign free = CW'(DEPTH) - mem_cnt - CW'(out_vld);

endmodule

// File: rtl/preamble_burst_capture.sv
// Captures a burst of decimated I/Q samples after each accepted preamble peak:
// skip cfg_offset samples, emit max(cfg_len,1) samples as one packet, then
// ignore cfg_holdoff samples before re-arming.
// Latency: sample written at edge k is on out.tdata after edge k+1.
// Backpressure: out.tready stalls the FIFO only; dec_stb is never stalled, a
// peak is accepted only if the whole packet fits, otherwise missed_peaks++.
// Ports: clk, reset, clear (sync, active-high, same effect), dec_stb/idec/qdec,
// peak_stb, cfg_offset/cfg_len/cfg_holdoff, out (AXI-Stream master), busy, missed_peaks.
// Build option: PREAMBLE_CAPTURE_TS_EN prepends a header word holding the
// dec_stb count at the peak cycle.
module preamble_burst_capture
    import preamble_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int MAX_LEN     = MAX_LEN_DEF,
    parameter int FIFO_AWIDTH = FIFO_AWIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          dec_stb,
    input  logic [DATA_WIDTH-1:0]         idec,
    input  logic [DATA_WIDTH-1:0]         qdec,
    input  logic                          peak_stb,
    input  logic [CFG_WIDTH-1:0]          cfg_offset,
    input  logic [$clog2(MAX_LEN+1)-1:0]  cfg_len,
    input  logic [CFG_WIDTH-1:0]          cfg_holdoff,
    preamble_burst_capture_if.master      out,
    output logic                          busy,
    output logic [MISS_WIDTH-1:0]         missed_peaks
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FREE_W = FIFO_AWIDTH + 1;
    localparam int WORD_W = 2 * DATA_WIDTH;

    cap_state_t             state_q, state_d;
    logic [CFG_WIDTH-1:0]   skip_q, skip_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [CFG_WIDTH-1:0]   hold_q, hold_d;
    logic                   accept;
    logic                   reject;
    logic                   push_smp;
    logic                   last_smp;
    logic                   flush;

    logic [LEN_W-1:0]       eff_len;
    logic [FREE_W-1:0]      need;
    logic [FREE_W-1:0]      fifo_free;
    logic                   push_vld;
    logic [WORD_W-1:0]      push_word;
    logic [WORD_W:0]        fifo_out;
    logic                   fifo_vld;

    assign flush   = reset | clear;
    assign eff_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign need    = FREE_W'(eff_len) + FREE_W'(HDR_EN);

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            len_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
        end
    end

    // The dec_stb sample on the peak cycle is consumed while still in IDLE,
    // so it never counts towards skip or capture.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        len_d    = len_q;
        hold_d   = hold_q;
        accept   = 1'b0;
        reject   = 1'b0;
        push_smp = 1'b0;
        last_smp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (peak_stb) begin
                    if (fifo_free >= need) begin
                        accept  = 1'b1;
                        skip_d  = cfg_offset;
                        len_d   = eff_len;
                        hold_d  = cfg_holdoff;
                        state_d = (cfg_offset == '0) ? ST_CAPTURE : ST_SKIP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (dec_stb) begin
                    skip_d = skip_q - CFG_WIDTH'(1);
                    if (skip_q == CFG_WIDTH'(1)) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (dec_stb) begin
                    push_smp = 1'b1;
                    len_d    = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        last_smp = 1'b1;
                        state_d  = (hold_q == '0) ? ST_IDLE : ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (dec_stb) begin
                    hold_d = hold_q - CFG_WIDTH'(1);
                    if (hold_q == CFG_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Header (if built) is pushed on the acceptance cycle, ahead of any sample.
    assign push_vld = push_smp | (accept & HDR_EN);

`ifdef PREAMBLE_CAPTURE_TS_EN
    logic [WORD_W-1:0] sample_cnt_q;

    always_ff @(posedge clk) begin
        if (flush) begin
            sample_cnt_q <= '0;
        end else if (dec_stb) begin
            sample_cnt_q <= sample_cnt_q + WORD_W'(1);
        end
    end

    assign push_word = accept ? sample_cnt_q : {idec, qdec};
`else
    assign push_word = {idec, qdec};
`endif

    always_ff @(posedge clk) begin
        if (flush) begin
            missed_peaks <= '0;
        end else if (reject && (missed_peaks != '1)) begin
            missed_peaks <= missed_peaks + MISS_WIDTH'(1);
        end
    end

    pbc_fifo #(
        .WIDTH  (WORD_W + 1),
        .AWIDTH (FIFO_AWIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (flush),
        .push     (push_vld),
        .push_dat ({push_word, last_smp}),
        .out_dat  (fifo_out),
        .out_vld  (fifo_vld),
        .out_rdy  (out.tready),
        .free     (fifo_free)
    );

    assign out.tdata  = fifo_out[WORD_W:1];
    assign out.tlast  = fifo_out[0];
    assign out.tvalid = fifo_vld;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_preamble_burst_capture.sv
// Bench for preamble_burst_capture: a directed vector table, hand-written
// corner sequences and a randomized phase, all scored against a sample-index
// model (each accepted peak defines a window of sample indices to capture).
module tb_preamble_burst_capture;
    import preamble_capture_pkg::*;

    localparam int DW    = 16;
    localparam int MAXL  = 4095;
    localparam int AW    = 12;
    localparam int LEN_W = 12;
    localparam int DEPTH = 4096;
    localparam int WW    = 2 * DW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              dec_stb = 1'b0;
    logic [DW-1:0]     idec = '0;
    logic [DW-1:0]     qdec = '0;
    logic              peak_stb = 1'b0;
    logic [15:0]       cfg_offset = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [15:0]       cfg_holdoff = '0;
    logic              busy;
    logic [7:0]        missed_peaks;

    preamble_burst_capture_if #(.DATA_WIDTH(DW)) out_if ();

    preamble_burst_capture #(
        .DATA_WIDTH (DW),
        .MAX_LEN    (MAXL),
        .FIFO_AWIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .dec_stb     (dec_stb),
        .idec        (idec),
        .qdec        (qdec),
        .peak_stb    (peak_stb),
        .cfg_offset  (cfg_offset),
        .cfg_len     (cfg_len),
        .cfg_holdoff (cfg_holdoff),
        .out         (out_if),
        .busy        (busy),
        .missed_peaks(missed_peaks)
    );

    always #5 clk = ~clk;

`ifdef PREAMBLE_CAPTURE_TS_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [WW-1:0] dat;
        logic          last;
    } word_t;

    word_t       exp_q[$];
    longint      smp_idx;      // dec_stb samples seen before the current cycle
    longint      win_lo, win_hi, rearm;
    int          exp_missed;
    logic        prev_stall;
    logic [WW-1:0] prev_dat;
    logic        prev_last;
    int          n_pop, n_last;
    logic [DW-1:0] ramp = '0;

    task automatic model_reset();
        exp_q.delete();
        smp_idx    = 0;
        win_lo     = 1;
        win_hi     = 0;
        rearm      = 0;
        exp_missed = 0;
        prev_stall = 1'b0;
    endtask

    // Called just after a falling edge; drives one cycle and scores it.
    task automatic step(input logic ds, input logic [DW-1:0] i, input logic [DW-1:0] q,
                        input logic pk, input logic rdy);
        longint occ, eff, first;
        word_t  w;
        dec_stb = ds; idec = i; qdec = q; peak_stb = pk; out_if.tready = rdy;
        #1;
        if (prev_stall) begin
            check("hold_vld", out_if.tvalid, 1);
            check("hold_dat", out_if.tdata, prev_dat);
            check("hold_last", out_if.tlast, prev_last);
        end
        occ = exp_q.size();
        if (out_if.tvalid && rdy) begin
            n_pop++;
            if (out_if.tlast) n_last++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_word: got %0h, expected no word", out_if.tdata);
            end else begin
                w = exp_q.pop_front();
                check("tdata", out_if.tdata, w.dat);
                check("tlast", out_if.tlast, w.last);
            end
        end
        if (ds && smp_idx >= win_lo && smp_idx <= win_hi) begin
            w.dat = {i, q}; w.last = (smp_idx == win_hi);
            exp_q.push_back(w);
        end
        if (pk && smp_idx >= rearm) begin
            eff = (cfg_len == 0) ? 1 : longint'(cfg_len);
            if (DEPTH - occ >= eff + HDR) begin
                first  = smp_idx + (ds ? 1 : 0);
                win_lo = first + longint'(cfg_offset);
                win_hi = win_lo + eff - 1;
                rearm  = win_hi + 1 + longint'(cfg_holdoff);
                if (HDR != 0) begin
                    w.dat = WW'(smp_idx); w.last = 1'b0;
                    exp_q.push_back(w);
                end
            end else if (exp_missed < 255) begin
                exp_missed++;
            end
        end
        prev_stall = out_if.tvalid && !rdy;
        prev_dat   = out_if.tdata;
        prev_last  = out_if.tlast;
        if (ds) smp_idx++;
        @(posedge clk);
        @(negedge clk);
        check("busy", busy, (smp_idx < rearm) ? 1 : 0);
        check("missed", missed_peaks, exp_missed);
    endtask

    task automatic tick(input logic pk, input logic rdy);
        step(1'b1, ramp, ramp + 16'h0100, pk, rdy);
        ramp = ramp + 16'd1;
    endtask

    task automatic do_reset(input bit use_clear);
        if (use_clear) clear = 1'b1; else reset = 1'b1;
        dec_stb = 1'b0; peak_stb = 1'b0; out_if.tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check("rst_tvalid", out_if.tvalid, 0);
        check("rst_tlast", out_if.tlast, 0);
        check("rst_tdata", out_if.tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_missed", missed_peaks, 0);
        reset = 1'b0; clear = 1'b0;
        ramp = '0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            c++;
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("drain_left", exp_q.size(), 0);
        check("drain_tvalid", out_if.tvalid, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          pk;
        logic          e_vld;
        logic [WW-1:0] e_dat;
        logic          e_last;
        logic          e_busy;
    } vec_t;

    vec_t tbl[24];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        // offset=3, len=4, holdoff=0; ramp sample k = {k, k+256}; peak on sample 10.
        // Samples 14..17 visible after edges 15..18, busy after edges 10..16.
        for (int k = 0; k < 24; k++) begin
            tbl[k].pk     = (k == 10);
            tbl[k].e_vld  = (k >= 15 && k <= 18) || (HDR != 0 && k == 11);
            tbl[k].e_dat  = (k == 11) ? WW'(10) : {16'(k - 1), 16'(k - 1 + 256)};
            tbl[k].e_last = (k == 18);
            tbl[k].e_busy = (k >= 10 && k <= 16);
        end

        @(negedge clk);
        do_reset(1'b0);

        cfg_offset = 16'd3; cfg_len = 12'd4; cfg_holdoff = 16'd0;
        for (int k = 0; k < 24; k++) begin
            tick(tbl[k].pk, 1'b1);
            check("tbl_vld", out_if.tvalid, tbl[k].e_vld);
            if (tbl[k].e_vld) begin
                check("tbl_dat", out_if.tdata, tbl[k].e_dat);
                check("tbl_last", out_if.tlast, tbl[k].e_last);
            end
            check("tbl_busy", busy, tbl[k].e_busy);
        end

        // Output stall of 20 cycles in the middle of a burst.
        do_reset(1'b0);
        cfg_offset = 16'd2; cfg_len = 12'd30; cfg_holdoff = 16'd3;
        tick(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b0);
        for (int k = 0; k < 40; k++) tick(1'b0, 1'b1);
        check("stall_busy_end", busy, 0);
        drain(100);

        // Long burst held in the FIFO; the next peak cannot fit and is counted.
        do_reset(1'b1);
        cfg_offset = 16'd0; cfg_len = 12'd4000; cfg_holdoff = 16'd2;
        tick(1'b1, 1'b0);
        for (int k = 0; k < 4005; k++) tick(1'b0, 1'b0);
        check("long_busy_done", busy, 0);
        tick(1'b1, 1'b0);
        check("long_missed", missed_peaks, 1);
        check("long_busy_rej", busy, 0);
        drain(4200);

        // Peaks inside SKIP/CAPTURE/last sample/HOLDOFF are ignored;
        // the first sample after holdoff re-arms.
        do_reset(1'b0);
        cfg_offset = 16'd2; cfg_len = 12'd3; cfg_holdoff = 16'd5;
        tick(1'b1, 1'b1);
        for (int r = 1; r <= 10; r++) tick(r == 1 || r == 4 || r == 5 || r == 8 || r == 10, 1'b1);
        check("ign_missed", missed_peaks, 0);
        check("ign_idle", busy, 0);
        tick(1'b1, 1'b1);
        check("rearm_busy", busy, 1);
        for (int k = 0; k < 12; k++) tick(1'b0, 1'b1);
        drain(50);

        // cfg_len = 0 gives a one-sample packet with tlast.
        do_reset(1'b1);
        cfg_offset = 16'd1; cfg_len = 12'd0; cfg_holdoff = 16'd0;
        n_pop = 0; n_last = 0;
        tick(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);
        check("len0_words", n_pop, 1 + HDR);
        check("len0_last", n_last, 1);

        // Reset in the middle of CAPTURE: nothing left over afterwards.
        cfg_offset = 16'd0; cfg_len = 12'd50; cfg_holdoff = 16'd0;
        tick(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1);
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1);
        check("post_rst_tvalid", out_if.tvalid, 0);

        // Randomized traffic.
        do_reset(1'b1);
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                cfg_offset  = 16'($urandom_range(0, 8));
                cfg_len     = LEN_W'($urandom_range(0, 24));
                cfg_holdoff = 16'($urandom_range(0, 6));
            end
            if (c == 1500) do_reset(1'b1);
            step($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom),
                 $urandom_range(0, 24) == 0, $urandom_range(0, 4) != 0);
        end
        drain(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
